// File: rtl/oam_dma.sv
// Sprite DMA: snoops CPU writes to the page register, halts the CPU and copies
// one 256-byte CPU page into the PPU OAM data port, one bus step per clk.
// Latency: cpu_halt rises trigger+1; holds 513 (HALT on odd parity) or 514 cycles.
// Backpressure: none on the bus; the CPU is stalled through cpu_halt while active.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cpu_addr/wdata/we      snooped CPU write bus (trigger source)
//   cpu_halt               stall request to the CPU core
//   dma_active             engine owns the bus (drives the mux ahead of the decoder)
//   dma_addr/we/wdata      bus master outputs while active
//   dma_rdata              combinational read data for dma_addr
module oam_dma #(
  parameter logic [15:0] PAGE_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  input  logic [7:0]  dma_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  // The byte index is 8 bits, so the final index is the 8-bit truncation.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state_q;
  state_t     state_d;
  logic       par_q;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic [7:0] byte_q;
  logic       trigger;

  assign trigger = cpu_we && (cpu_addr == PAGE_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      par_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_q <= cpu_wdata;
            idx_q  <= 8'h00;
          end
        end
        S_READ:  byte_q <= dma_rdata;
        // Wraps to 0 on the last byte, leaving idx clean for the next transfer.
        S_WRITE: idx_q <= idx_q + 8'h01;
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the cpu_* inputs.
  always_comb begin
    state_d    = state_q;
    cpu_halt   = 1'b0;
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_we     = 1'b0;
    dma_wdata  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_HALT;
      end
      S_HALT: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        // Reads must land on even parity; insert ALIGN when HALT is even.
        state_d    = par_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        state_d    = S_READ;
      end
      S_READ: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        dma_addr   = {page_q, idx_q};
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        dma_addr   = OAM_DATA_ADDR;
        dma_we     = 1'b1;
        dma_wdata  = byte_q;
        state_d    = (idx_q == LAST_IDX) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine between the 6502 CPU core and the CPU-side address decoder.
- Snoops CPU writes for a write to the page register (0x4014). On a hit it halts the CPU and takes the CPU bus.
- Copies 256 bytes from CPU page {page,8'h00..8'hFF} into the PPU OAM data port (0x2004).
- Its bus outputs are muxed ahead of the decoder whenever dma_active is high.

Parameters:
- PAGE_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written for every byte.
- XFER_LEN, 256, bytes per transfer; must equal 256 (8-bit index wraps).

Ports:
- clk  input  1  system clock (CPU clock enable domain, one transfer step per clk).
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- cpu_addr  input  16  CPU bus address.
- cpu_wdata  input  8  CPU write data.
- cpu_we  input  1  CPU write strobe, valid for one cycle per write.
- cpu_halt  output  1  stall request to the CPU core.
- dma_active  output  1  high while the engine owns the bus.
- dma_addr  output  16  bus address driven while active.
- dma_we  output  1  bus write strobe driven while active.
- dma_wdata  output  8  bus write data.
- dma_rdata  input  8  bus read data; combinational, valid in the same cycle as dma_addr.

Behaviour:
- Internal registers:
  - par: cycle parity, toggles every clk, 0 after reset.
  - page[7:0]: source page.
  - idx[7:0]: byte index.
  - buf[7:0]: byte being moved.
  - state: IDLE, HALT, ALIGN, READ or WRITE.
- Reset (synchronous, any state, including mid-transfer):
  - state=IDLE, par=0, idx=0, page=0, buf=0.
  - All outputs 0 in the following cycle. A partial transfer is abandoned and is not resumed.
- IDLE:
  - Outputs are 0.
  - Trigger condition: cpu_we && cpu_addr==PAGE_REG_ADDR. On trigger: page<=cpu_wdata, idx<=0, state<=HALT.
  - The CPU write cycle itself completes normally; cpu_halt stays low in the trigger cycle.
- HALT (one dummy cycle):
  - cpu_halt=1, dma_active=1, dma_we=0, dma_addr=0.
  - Next state: par==1 -> READ; par==0 -> ALIGN.
  - Result: READ always lands on a par==0 cycle.
- ALIGN (one cycle):
  - Same outputs as HALT.
  - Next state: READ.
- READ:
  - dma_addr={page,idx}, dma_we=0.
  - buf<=dma_rdata at the clk edge.
  - Next state: WRITE.
- WRITE:
  - dma_addr=OAM_DATA_ADDR, dma_we=1, dma_wdata=buf.
  - If idx==8'hFF: state<=IDLE. Otherwise idx<=idx+1 and state<=READ.
- Output rules:
  - All outputs are decoded from registered state. No combinational path exists from cpu_* to any output.
  - cpu_halt and dma_active are high in exactly HALT, ALIGN, READ and WRITE.
  - dma_addr and dma_wdata are 0 when not in READ or WRITE.
- Latency:
  - First cpu_halt cycle is trigger+1.
  - Total cpu_halt-high cycles: 513 when HALT falls on par==1, 514 when HALT falls on par==0.
  - cpu_halt drops in the cycle after the final WRITE.
- Boundary cases:
  - Triggers while state!=IDLE are ignored; the CPU is halted, so none are expected.
  - A trigger in the same cycle that the final WRITE completes is ignored. A trigger in the next cycle (IDLE) starts a new transfer.
  - Page 0xFF ends at source 0xFFFF with no wrap into the next page. idx wraps only at termination.
  - Writes to other addresses, and reads of 0x4014, have no effect.

Test Plan:
- Reset: assert rst 2 cycles in arbitrary state -> all outputs 0, state IDLE; cpu_we to 0x4015 with data 0x02 -> no activity for 600 cycles.
- Odd alignment: trigger with data 0x02 so HALT lands on par==1 -> cpu_halt high exactly 513 cycles. First READ addr 0x0200, then WRITE to 0x2004. Last READ addr 0x02FF.
- Even alignment: trigger so HALT lands on par==0 -> one ALIGN cycle, cpu_halt high exactly 514 cycles, every READ on par==0.
- Data integrity: model memory with mem[0x0300+i]=i^8'h5A, trigger page 0x03 -> 256 dma_we pulses, all at 0x2004, data sequence 0x5A,0x5B,...,0xA5 in order. No dma_we during HALT or ALIGN.
- Reset mid-transfer: assert rst when idx==100 -> next cycle all outputs 0. New trigger with page 0x07 restarts at 0x0700 and completes the full 256 bytes.
- Back-to-back: second trigger the cycle after cpu_halt falls -> new transfer starts normally. Trigger during the final WRITE cycle -> ignored.
